regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential reader that walks every entry of the NPC general-purpose register file through its asynchronous read port and streams the contents out over a valid/ready interface. It drives the register file's read address, captures the returned word, and presents it with its index to a consumer such as the difftest bridge or a debug dump path. A dump is started by a single-cycle request and ends with a one-cycle `done` pulse.

## Interface
- `ADDR_WIDTH`, 5: register-file address width; dump length is 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, 32: register word width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last entry is accepted.
- `rf_addr`  out  ADDR_WIDTH  read address to register-file read port.
- `rf_rdata`  in  DATA_WIDTH  asynchronous read data for `rf_addr`; entry 0 reads as 0.
- `out_valid`  out  1  `out_data`/`out_idx` valid.
- `out_ready`  in  1  consumer accepts when high together with `out_valid`.
- `out_data`  out  DATA_WIDTH  captured register value.
- `out_idx`  out  ADDR_WIDTH  index of `out_data`.
- `out_last`  out  1  high with the final entry (index 2**ADDR_WIDTH-1).
- `out_csum`  out  DATA_WIDTH  running XOR checksum (see Configuration).

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: `start`=1 -> LOAD, index counter cleared to 0, checksum cleared to 0. Otherwise stay.
- LOAD: `rf_addr` = index; on the clock edge, `rf_rdata` is registered into `out_data`, the index into `out_idx`, and `out_last` is set to (index == max) -> SEND.
- SEND: `out_valid`=1; `out_data`, `out_idx`, and `out_last` are held stable until the handshake. On `out_valid && out_ready`: if `out_last` -> DONE, else index+1 -> LOAD.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` outside IDLE is ignored; no queuing.
- No snapshot guarantee: each entry reflects register-file state in its own LOAD cycle. Writes to the register file during a dump are visible in later entries only.
- Entry 0 is always emitted with data 0.
- The index counter is ADDR_WIDTH+0 bits. The termination decision uses `out_last`, never counter wrap, so the counter never wraps.
- Reset in any state: synchronous return to IDLE on the next edge. The partial dump is discarded; no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_idx`=0, `rf_addr`=0, `out_csum`=0.
- `rf_addr` is driven from the index register and is stable during LOAD.
- Latency: `start` at cycle N -> LOAD at N+1 -> first `out_valid` at N+2.
- With `out_ready` held high: 2 cycles per entry. A full 32-entry dump runs 64 cycles from the first LOAD; `done` follows in the cycle after the last accept.
- `out_ready` low stalls SEND indefinitely with outputs unchanged.
- `out_valid` does not depend combinationally on `out_ready`.

## Configuration
- `REGFILE_DUMP_CSUM_EN` defined:
  - on each accepted entry, `out_csum` <= `out_csum` ^ `out_data`;
  - the final value is valid in the DONE cycle and holds until the next accepted `start`.
- Not defined: `out_csum` is tied to 0 and no checksum register exists.

## Structure
- Shared package `regfile_dump_pkg`: state enum (IDLE, LOAD, SEND, DONE).
- Single module; no sub-module is natural, since the counter and FSM are trivially small.
- The bench instantiates the existing register file alongside this block and connects it to `rf_addr`/`rf_rdata`.

## Test plan
- Preload x1..x31 = 0x1000+i, `out_ready`=1, pulse `start` -> 32 beats in order:
  - idx 0 data 0, idx 5 data 0x1005, idx 31 data 0x101F with `out_last`=1;
  - `done` one cycle after the idx-31 accept; 64 cycles from first LOAD.
- Backpressure: `out_ready` low for 10 cycles during idx 3 -> `out_valid` held, idx 3 data 0x1003 unchanged; resumes at idx 4 with no loss or duplication.
- Pulse `start` again at idx 10 mid-dump -> ignored; sequence and `done` unchanged.
- `rst_n`=0 for one cycle at idx 7 -> next cycle IDLE, all outputs at reset values, no `done`; a new `start` restarts from idx 0.
- Register-file write x20 = 0xDEAD during the idx 5 SEND -> idx 20 reports 0xDEAD.
- With `REGFILE_DUMP_CSUM_EN`: x1 = 0xF0F0, x2 = 0x0FF0, rest 0 -> `out_csum` = 0xFF00 at `done`. Without the macro: `out_csum` stays 0.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump reader.
package regfile_dump_pkg;

  localparam int unsigned RD_ADDR_WIDTH = 5;
  localparam int unsigned RD_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks every register-file entry through the async read port and streams it out
// over valid/ready. Optional running XOR checksum enabled by REGFILE_DUMP_CSUM_EN.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RD_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_csum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]   out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic accept;
  assign accept = out_valid_q && out_ready;

  // Next-state and capture logic; status flags are registered from the next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        out_data_d = rf_rdata;
        out_idx_d  = idx_q;
        out_last_d = (idx_q == LAST_IDX);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef REGFILE_DUMP_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  // Cleared on an accepted start, folded in on every accepted beat.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && start) begin
      csum_d = '0;
    end else if (state_q == ST_SEND && accept) begin
      csum_d = csum_q ^ out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign out_csum = csum_q;
`else
  assign out_csum = '0;
`endif

  assign rf_addr   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump with a bench-side register file and a
// beat-level reference model; checksum expectations follow REGFILE_DUMP_CSUM_EN.
module tb_regfile_dump;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NENT = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rf_addr, out_idx;
  logic [DW-1:0] rf_rdata, out_data, out_csum;

  logic [DW-1:0] regs [NENT];

  always #5 clk = ~clk;

  assign rf_rdata = (rf_addr == '0) ? '0 : regs[rf_addr];

  regfile_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_csum  (out_csum)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rf_val(input int idx);
    return (idx == 0) ? '0 : regs[idx];
  endfunction

  function automatic logic [DW-1:0] csum_exp(input logic [DW-1:0] m);
`ifdef REGFILE_DUMP_CSUM_EN
    return m;
`else
    return ((m & '0) | '0);
`endif
  endfunction

  // Reference model: a dump is a sequence of beats, each loaded then offered.
  bit            m_active = 0, m_loading = 0, m_valid = 0, m_done = 0;
  bit            m_rst_chk = 0, chk_en = 0;
  int            m_idx = 0, first_load = 0;
  logic [DW-1:0] m_data = '0, m_csum = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_loading = 0; m_valid = 0; m_done = 0;
      m_idx = 0; m_csum = '0; m_rst_chk = 1; chk_en = 1;
    end else begin
      m_rst_chk = 0;
      if (m_done) begin
        m_done = 0; m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_loading = 1; m_idx = 0; m_csum = '0; first_load = cyc;
        end
      end else if (m_loading) begin
        m_data = rf_val(m_idx); m_loading = 0; m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_csum ^= m_data;
        m_valid = 0;
        if (m_idx == NENT - 1) m_done = 1;
        else begin m_idx++; m_loading = 1; end
      end
    end
  end

  logic [DW-1:0] beat_data [NENT];
  logic          beat_last [NENT];
  int            beat_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [DW-1:0] csum_at_done = '0;

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_active));
      check("done", 64'(done), 64'(m_done));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_csum", 64'(out_csum), 64'(csum_exp(m_csum)));
      if (m_rst_chk) begin
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_idx", 64'(out_idx), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_rf_addr", 64'(rf_addr), 64'(0));
      end
      if (m_loading) check("rf_addr", 64'(rf_addr), 64'(m_idx));
      if (m_valid) begin
        check("out_idx", 64'(out_idx), 64'(m_idx));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_last", 64'(out_last), 64'(m_idx == NENT - 1));
      end
      if (out_valid && out_ready && rst_n) begin
        beat_data[out_idx] = out_data;
        beat_last[out_idx] = out_last;
        beat_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        csum_at_done = out_csum;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < NENT; i++) regs[i] = 32'h1000 + DW'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    for (int j = 0; j < 400; j++) begin
      if (m_valid && m_idx == k) break;
      tick();
    end
    check("reach_valid", 64'(out_valid), 64'(1));
    check("reach_idx", 64'(out_idx), 64'(k));
  endtask

  task automatic run_to_done();
    int d0;
    d0 = done_cnt;
    for (int j = 0; j < 600; j++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check("dump_done_seen", 64'(done_cnt - d0), 64'(1));
    tick();
  endtask

  int b0, d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NENT; i++) regs[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high.
    preload();
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    run_to_done();
    check("t1_beats", 64'(beat_cnt - b0), 64'(32));
    check("t1_idx0", 64'(beat_data[0]), 64'(0));
    check("t1_idx5", 64'(beat_data[5]), 64'(32'h1005));
    check("t1_idx31", 64'(beat_data[31]), 64'(32'h101F));
    check("t1_last31", 64'(beat_last[31]), 64'(1));
    check("t1_last30", 64'(beat_last[30]), 64'(0));
    check("t1_latency", 64'(done_cyc - first_load), 64'(64));
    check("t1_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Backpressure on idx 3.
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    wait_idx(3);
    out_ready = 1'b0;
    repeat (10) tick();
    check("t2_stall_idx", 64'(out_idx), 64'(3));
    check("t2_stall_data", 64'(out_data), 64'(32'h1003));
    out_ready = 1'b1;
    run_to_done();
    check("t2_beats", 64'(beat_cnt - b0), 64'(32));
    check("t2_idx4", 64'(beat_data[4]), 64'(32'h1004));
    check("t2_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Start mid-dump is ignored.
    b0 = beat_cnt; d0 = done_cnt;
    pulse_start();
    wait_idx(10);
    pulse_start();
    run_to_done();
    check("t3_beats", 64'(beat_cnt - b0), 64'(32));
    check("t3_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t3_latency", 64'(done_cyc - first_load), 64'(64));

    // Reset mid-dump discards it, then restart.
    d0 = done_cnt;
    pulse_start();
    wait_idx(7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_out_idx", 64'(out_idx), 64'(0));
    repeat (20) tick();
    check("t4_no_done", 64'(done_cnt - d0), 64'(0));
    b0 = beat_cnt;
    pulse_start();
    run_to_done();
    check("t4_beats", 64'(beat_cnt - b0), 64'(32));
    check("t4_idx0", 64'(beat_data[0]), 64'(0));

    // Register-file write during the idx 5 beat shows up at idx 20.
    preload();
    pulse_start();
    wait_idx(5);
    regs[20] = 32'hDEAD;
    run_to_done();
    check("t5_idx20", 64'(beat_data[20]), 64'(32'hDEAD));
    check("t5_idx19", 64'(beat_data[19]), 64'(32'h1013));

    // Checksum.
    for (int i = 0; i < NENT; i++) regs[i] = '0;
    regs[1] = 32'hF0F0;
    regs[2] = 32'h0FF0;
    pulse_start();
    run_to_done();
`ifdef REGFILE_DUMP_CSUM_EN
    check("t6_csum_done", 64'(csum_at_done), 64'(32'hFF00));
    repeat (5) tick();
    check("t6_csum_hold", 64'(out_csum), 64'(32'hFF00));
`else
    check("t6_csum_done", 64'(csum_at_done), 64'(0));
    repeat (5) tick();
    check("t6_csum_hold", 64'(out_csum), 64'(0));
`endif

    // Randomized traffic: backpressure, writes, stray starts, occasional reset.
    for (int i = 0; i < NENT; i++) regs[i] = $urandom;
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) regs[$urandom_range(0, NENT - 1)] = $urandom;
      tick();
    end
    start = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (80) tick();
    check("rand_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
